// File: rtl/axi_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_ram_slave
// Description : AXI4 slave over a single-port 32-bit word RAM. Serves one
//               INCR burst (1-256 beats) at a time. Beats that fall outside
//               the RAM window are answered with SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int          c_AW   = $clog2(DEPTH);
    localparam logic [31:0] c_SPAN = 32'(DEPTH) << 2;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WDATA  = 3'd1;
    localparam logic [2:0] c_WRESP  = 3'd2;
    localparam logic [2:0] c_RFETCH = 3'd3;
    localparam logic [2:0] c_RDATA  = 3'd4;

    logic [2:0]  r_state;
    logic        r_prio_w;
    logic        r_err;
    logic        r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic        r_rvalid;
    logic        r_rlast;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_mem [DEPTH];

    logic            w_idle;
    logic            w_awready;
    logic            w_arready;
    logic [32:0]     w_off;
    logic            w_in_range;
    logic [c_AW-1:0] w_idx;
    logic            w_last;
    logic            w_wr_en;

    assign w_idle    = (r_state == c_IDLE);
    assign w_awready = w_idle && S_AXI_AWVALID && (!S_AXI_ARVALID || r_prio_w);
    assign w_arready = w_idle && S_AXI_ARVALID && (!S_AXI_AWVALID || !r_prio_w);

    // Bit 32 of the 33-bit offset is the borrow, i.e. addr below BASE_ADDR.
    assign w_off      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_off[32] && (w_off[31:0] < c_SPAN);
    assign w_idx      = w_off[c_AW+1:2];
    assign w_last     = (r_beat == r_len);
    assign w_wr_en    = !RST && (r_state == c_WDATA) && S_AXI_WVALID && w_in_range;

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_WREADY  = (r_state == c_WDATA);
    assign S_AXI_BVALID  = (r_state == c_WRESP);
    assign S_AXI_BRESP   = {r_err, 1'b0};
    assign S_AXI_BID     = r_id;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RLAST   = r_rlast;

    // RAM contents survive reset; only the beat in flight during reset is dropped.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            if (S_AXI_WSTRB[0]) r_mem[w_idx][7:0]   <= S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) r_mem[w_idx][15:8]  <= S_AXI_WDATA[15:8];
            if (S_AXI_WSTRB[2]) r_mem[w_idx][23:16] <= S_AXI_WDATA[23:16];
            if (S_AXI_WSTRB[3]) r_mem[w_idx][31:24] <= S_AXI_WDATA[31:24];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_prio_w <= 1'b1;
            r_err    <= 1'b0;
            r_id     <= 1'b0;
            r_addr   <= 32'h0;
            r_len    <= 8'h0;
            r_beat   <= 8'h0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
            r_rresp  <= 2'b00;
            r_rlast  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_awready) begin
                        r_addr  <= S_AXI_AWADDR;
                        r_len   <= S_AXI_AWLEN;
                        r_id    <= S_AXI_AWID;
                        r_err   <= 1'b0;
                        r_beat  <= 8'h0;
                        r_state <= c_WDATA;
                    end else if (w_arready) begin
                        r_addr  <= S_AXI_ARADDR;
                        r_len   <= S_AXI_ARLEN;
                        r_id    <= S_AXI_ARID;
                        r_err   <= 1'b0;
                        r_beat  <= 8'h0;
                        r_state <= c_RFETCH;
                    end
                end
                c_WDATA: begin
                    if (S_AXI_WVALID) begin
                        if (!w_in_range) r_err <= 1'b1;
                        r_addr <= r_addr + 32'd4;
                        r_beat <= r_beat + 8'd1;
                        if (w_last) r_state <= c_WRESP;
                    end
                end
                c_WRESP: begin
                    if (S_AXI_BREADY) begin
                        r_prio_w <= !r_prio_w;
                        r_state  <= c_IDLE;
                    end
                end
                c_RFETCH: begin
                    r_rdata  <= w_in_range ? r_mem[w_idx] : 32'h0;
                    r_rresp  <= w_in_range ? 2'b00 : 2'b10;
                    r_rlast  <= w_last;
                    r_rvalid <= 1'b1;
                    r_state  <= c_RDATA;
                end
                c_RDATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_prio_w <= !r_prio_w;
                            r_state  <= c_IDLE;
                        end else begin
                            r_addr  <= r_addr + 32'd4;
                            r_beat  <= r_beat + 8'd1;
                            r_state <= c_RFETCH;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 slave (responder) wrapping a single-port word-addressed RAM. It answers the core's AXI master port in simulation and FPGA bring-up, covering the AW/W/B write and AR/R read channels. Only one transaction is in flight at a time: INCR bursts of 1–256 beats, 32-bit beats, and byte strobes.

## Interface
- BASE_ADDR, 32'h0, byte address of RAM word 0.
- DEPTH, 4096, RAM size in 32-bit words (power of two); word index width AW = clog2(DEPTH).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- S_AXI_AWID  in  1  write ID, captured at AW handshake.
- S_AXI_AWADDR  in  32  write burst start byte address.
- S_AXI_AWLEN  in  8  write beats minus 1.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accepted.
- S_AXI_WDATA  in  32  write beat data.
- S_AXI_WSTRB  in  4  byte enables, bit i ↔ WDATA[8i+7:8i].
- S_AXI_WVALID  in  1  write beat valid.
- S_AXI_WREADY  out  1  write beat accepted.
- S_AXI_BID  out  1  response ID (= captured AWID).
- S_AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  master accepts response.
- S_AXI_ARID  in  1  read ID, captured at AR handshake.
- S_AXI_ARADDR  in  32  read burst start byte address.
- S_AXI_ARLEN  in  8  read beats minus 1.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accepted.
- S_AXI_RID  out  1  read ID (= captured ARID).
- S_AXI_RDATA  out  32  read beat data.
- S_AXI_RRESP  out  2  per-beat OKAY/SLVERR.
- S_AXI_RLAST  out  1  final beat of burst.
- S_AXI_RVALID  out  1  read beat valid.
- S_AXI_RREADY  in  1  master accepts beat.

Size, burst type, LOCK/CACHE/PROT/QOS, USER and WLAST are not ports. Bursts are always INCR by 4 bytes, and the beat counter alone ends a write burst.

## Operation
- FSM states: IDLE, WDATA, WRESP, RFETCH, RDATA.
- IDLE: AWREADY = AWVALID∧(¬ARVALID∨prio_w); ARREADY = ARVALID∧(¬AWVALID∨¬prio_w). This is combinational from VALID and is the only READY→VALID dependency.
  - prio_w resets to 1 and toggles after every completed transaction, giving round-robin on simultaneous AW/AR.
- Handshake latches addr, len, id, sets err=0, beat=0. AW goes to WDATA; AR goes to RFETCH.
- In-range test: BASE_ADDR ≤ addr < BASE_ADDR+4·DEPTH, using a 33-bit compare. Word index = (addr−BASE_ADDR)[AW+1:2]; addr[1:0] is ignored.
- WDATA: WREADY=1.
  - Each WVALID beat writes the strobed bytes if in range; out of range, the write is dropped and err=1.
  - addr += 4 (32-bit wrap); beat++. After beat == len, go to WRESP.
- WRESP: BVALID=1, BRESP = err ? 2'b10 : 2'b00. BREADY moves to IDLE.
- RFETCH: issue the RAM read (1-cycle synchronous), go to RDATA.
- RDATA: RVALID=1 with RDATA held stable. Out of range gives RDATA=0 and RRESP=2'b10; RLAST = (beat == len).
  - On RREADY: if last go to IDLE, else addr += 4, beat++, go to RFETCH.
- Bursts crossing the RAM end are not wrapped: the beats past the end get SLVERR. No 4 KB-boundary check.
- RAM contents are not affected by RST.

## Timing
- Reset values: all READY/VALID 0, BID=RID=0, BRESP=RRESP=2'b00, RDATA=0, RLAST=0, state IDLE, prio_w=1.
- Outputs other than IDLE-state AWREADY/ARREADY are registered or decoded from state.
- Write burst of N beats with no stalls: AW cycle, N W cycles, BVALID in the next cycle.
- Read: first RVALID 2 cycles after the AR handshake; one beat per 2 cycles thereafter.
- A VALID held while READY=0 is not consumed. RDATA/RRESP/RLAST are stable while RVALID∧¬RREADY.
- RST mid-burst aborts immediately; the next cycle shows reset values. Partially written beats remain in RAM.

## Test plan
- Single write 0x1234_5678 @0x10, WSTRB=4'hF, then read @0x10 → BRESP=00, RDATA=0x1234_5678, RLAST=1, RID=ARID.
- AWLEN=3 @0x100 with data 1..4, then ARLEN=3 with RREADY toggling every cycle → RDATA 1,2,3,4 in order, RLAST only on the 4th beat, data stable through stalls.
- Write 0xFFFF_FFFF, then WSTRB=4'b0101 data 0 → readback 0xFF00_FF00.
- Read @BASE_ADDR+4·DEPTH−4 with ARLEN=1 → beat0 OKAY, beat1 RDATA=0 and RRESP=10. A write burst with the same range → BRESP=10, word 0 untouched.
- AWVALID and ARVALID asserted in the same cycle, twice in a row → write served first, then read, then write; no deadlock.
- RST asserted during beat 2 of an 8-beat write → next cycle all VALID/READY=0; a new read afterwards returns beats 0–1 new, beats 2+ old.
